// File: rtl/seq_array_divider.sv
// rtl/seq_array_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_array_divider #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [n-1:0]    p;
    logic [n-1:0]    dividend;
    logic [n-1:0]    divisor;
    logic [CW-1:0]   cnt;

    logic [n:0]      shifted;
    logic [n:0]      diff;
    logic            neg;
    logic [n-1:0]    p_next;
    logic [n-1:0]    dividend_next;

    // The partial remainder always stays below the divisor, so n bits of storage
    // suffice; the n+1-bit subtract exposes the borrow as the sign bit.
    always_comb begin
        shifted       = {p, dividend[n-1]};
        diff          = shifted - {1'b0, divisor};
        neg           = diff[n];
        p_next        = neg ? shifted[n-1:0] : diff[n-1:0];
        dividend_next = {dividend[n-2:0], ~neg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p           <= '0;
            dividend    <= '0;
            divisor     <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (B == '0) begin
                            state       <= DONE;
                            Q           <= '1;
                            R           <= A;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state    <= CALC;
                            dividend <= A;
                            divisor  <= B;
                            p        <= '0;
                            cnt      <= CW'(n);
                            busy     <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    // Quotient bits enter the dividend register from the LSB as its MSBs leave.
                    p        <= p_next;
                    dividend <= dividend_next;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        Q           <= dividend_next;
                        R           <= p_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_divider.sv
// tb/tb_seq_array_divider.sv - directed and swept checks of seq_array_divider at n=8
module tb_seq_array_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [7:0] Q;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_array_divider #(.n(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Drives one accepting edge; operands are scrambled afterwards.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
    endtask

    // Returns edges after acceptance until done (-1 on timeout) and busy samples seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (Q !== 8'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", Q); end
        checks++; if (R !== 8'd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", R); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        launch(8'd200, 8'd7);
        wait_done(lat, bcnt);
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (bcnt != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt); end
        checks++; if (Q !== 8'd28) begin errors++; $display("FAIL basic_q: got %0d expected 28", Q); end
        checks++; if (R !== 8'd4) begin errors++; $display("FAIL basic_r: got %0d expected 4", R); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (Q !== 8'd28 || R !== 8'd4) begin errors++; $display("FAIL basic_hold: got %0d/%0d expected 28/4", Q, R); end
    endtask

    task automatic test_patterns();
        logic [7:0] ta [3] = '{8'd255, 8'd5, 8'd255};
        logic [7:0] tb [3] = '{8'd1, 8'd9, 8'd255};
        logic [7:0] tq [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0] tr [3] = '{8'd0, 8'd5, 8'd0};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            launch(ta[i], tb[i]);
            wait_done(lat, bcnt);
            checks++; if (lat != 8) begin errors++; $display("FAIL pattern%0d_latency: got %0d expected 8", i, lat); end
            checks++; if (Q !== tq[i]) begin errors++; $display("FAIL pattern%0d_q: got %0d expected %0d", i, Q, tq[i]); end
            checks++; if (R !== tr[i]) begin errors++; $display("FAIL pattern%0d_r: got %0d expected %0d", i, R, tr[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        @(posedge clk);
        #1;
        launch(8'd13, 8'd0);
        wait_done(lat, bcnt);
        checks++; if (lat != 0) begin errors++; $display("FAIL dz_latency: got %0d expected 0", lat); end
        checks++; if (bcnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %0d/%b expected 0/0", bcnt, busy); end
        checks++; if (Q !== 8'd255) begin errors++; $display("FAIL dz_q: got %0d expected 255", Q); end
        checks++; if (R !== 8'd13) begin errors++; $display("FAIL dz_r: got %0d expected 13", R); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
        @(posedge clk);
        #1;
        checks++; if (div_by_zero !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL dz_hold: got dbz=%b done=%b expected 1/0", div_by_zero, done); end
        launch(8'd10, 8'd3);
        wait_done(lat, bcnt);
        checks++; if (Q !== 8'd3 || R !== 8'd1) begin errors++; $display("FAIL dz_next_qr: got %0d/%0d expected 3/1", Q, R); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_ignored_start();
        int lat, bcnt;
        launch(8'd100, 8'd10);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (Q !== 8'd3 || R !== 8'd1) begin errors++; $display("FAIL ign_mid_hold: got %0d/%0d expected 3/1", Q, R); end
        launch(8'd1, 8'd1);
        wait_done(lat, bcnt);
        checks++; if (lat != 5) begin errors++; $display("FAIL ign_latency: got %0d expected 5", lat); end
        checks++; if (Q !== 8'd10 || R !== 8'd0) begin errors++; $display("FAIL ign_qr: got %0d/%0d expected 10/0", Q, R); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_precond_done: got %b expected 1", done); end
        launch(8'd9, 8'd2);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_enter_calc: got busy=%b done=%b expected 1/0", busy, done); end
        wait_done(lat, bcnt);
        checks++; if (lat != 8 || bcnt != 8) begin errors++; $display("FAIL b2b_timing: got %0d/%0d expected 8/8", lat, bcnt); end
        checks++; if (Q !== 8'd4 || R !== 8'd1) begin errors++; $display("FAIL b2b_qr: got %0d/%0d expected 4/1", Q, R); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        int seen_done;
        @(posedge clk);
        #1;
        launch(8'd77, 8'd5);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (Q !== 8'd0 || R !== 8'd0) begin errors++; $display("FAIL rmid_qr: got %0d/%0d expected 0/0", Q, R); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_flags: got %b%b%b expected 000", busy, done, div_by_zero); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", seen_done); end
        launch(8'd77, 8'd5);
        wait_done(lat, bcnt);
        checks++; if (lat != 8) begin errors++; $display("FAIL rmid_latency: got %0d expected 8", lat); end
        checks++; if (Q !== 8'd15 || R !== 8'd2) begin errors++; $display("FAIL rmid_qr_after: got %0d/%0d expected 15/2", Q, R); end
    endtask

    task automatic test_sweep();
        int lat, bcnt;
        int a, b;
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            launch(8'(a), 8'(b));
            wait_done(lat, bcnt);
            checks++; if (lat != 8) begin errors++; $display("FAIL sweep_latency %0d/%0d: got %0d expected 8", a, b, lat); end
            checks++; if (int'(Q) != a / b) begin errors++; $display("FAIL sweep_q %0d/%0d: got %0d expected %0d", a, b, Q, a / b); end
            checks++; if (int'(R) != a % b) begin errors++; $display("FAIL sweep_r %0d/%0d: got %0d expected %0d", a, b, R, a % b); end
            checks++; if (int'(Q) * b + int'(R) != a || int'(R) >= b) begin errors++; $display("FAIL sweep_identity %0d/%0d: got q=%0d r=%0d", a, b, Q, R); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
